gpu_core: RTL and testbench

// - Single-issue scalar compute core of the DSP/GPU array. Loads an instruction block plus optional R0 seed on Start.
// - Executes the block in order; LD/ST go through a blocking memory handshake. Raises Ready on READY or end of block.

---
 rtl/gpu_core_if.sv | 27 ++
 rtl/gpu_core.sv | 214 +++++++++++++++++++++
 tb/tb_gpu_core.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_core_if.sv
// gpu_core_if: memory handshake bundle between gpu_core and its data memory.
//   rd_data_M  memory -> core  read data
//   ready_M    memory -> core  access complete
//   wr_data_M  core -> memory  write data
//   addr_M     core -> memory  access address
//   enable_M   core -> memory  00 idle, 01 read, 10 write
// Modport master is the core side, slave is the memory side.
interface gpu_core_if #(
  parameter int REG_W  = 8,
  parameter int ADDR_W = 8
);
  logic [REG_W-1:0]  rd_data_M;
  logic              ready_M;
  logic [REG_W-1:0]  wr_data_M;
  logic [ADDR_W-1:0] addr_M;
  logic [1:0]        enable_M;

  modport master (
    input  rd_data_M, ready_M,
    output wr_data_M, addr_M, enable_M
  );

  modport slave (
    output rd_data_M, ready_M,
    input  wr_data_M, addr_M, enable_M
  );
endinterface

// File: rtl/gpu_core.sv
// gpu_core: single-issue scalar compute core. On Start it latches a block of
// NUM_INSN instructions (and optionally an R0 seed), executes them in order one
// per cycle, performs LD/ST through a blocking memory handshake, and raises
// Ready after a READY instruction or after the last instruction of the block.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   init_R0_flag  on Start: 1 = seed R0 from init_R0_data, 0 = R0 cleared
//   init_R0_data  R0 seed value
//   insn_data     instruction block, insn k at [(k+1)*INSN_W-1 : k*INSN_W]
//   Start         one-cycle launch pulse, honoured only while idle
//   Ready         1 = idle / block finished
//   mem           memory handshake (gpu_core_if.master)
//
// Build option: define GPU_CORE_SAT_ARITH_EN to make ADD saturate at
// 2^REG_W-1 and SUB saturate at 0 (unsigned); otherwise both wrap.
module gpu_core #(
  parameter int REG_W    = 8,
  parameter int ADDR_W   = 8,
  parameter int INSN_W   = 16,
  parameter int OPC_W    = 4,
  parameter int NUM_INSN = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init_R0_flag,
  input  logic [REG_W-1:0]           init_R0_data,
  input  logic [NUM_INSN*INSN_W-1:0] insn_data,
  input  logic                       Start,
  output logic                       Ready,
  gpu_core_if.master                 mem
);

  localparam int PC_W = (NUM_INSN > 1) ? $clog2(NUM_INSN) : 1;
  localparam int NREG = 16;

  localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_OR    = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_XOR   = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_CMPGE = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_LD    = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_ST    = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_READY = OPC_W'(9);

  localparam logic [1:0] EN_IDLE = 2'b00;
  localparam logic [1:0] EN_RD   = 2'b01;
  localparam logic [1:0] EN_WR   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              ready_q, ready_d;
  logic [1:0]        en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REG_W-1:0]  wdata_q, wdata_d;
  logic              first_q, first_d;
  logic [INSN_W-1:0] insn_q [NUM_INSN];
  logic [INSN_W-1:0] insn_d [NUM_INSN];
  logic [REG_W-1:0]  regs_q [NREG];
  logic [REG_W-1:0]  regs_d [NREG];

  function automatic logic [REG_W-1:0] add_op(input logic [REG_W-1:0] a,
                                              input logic [REG_W-1:0] b);
`ifdef GPU_CORE_SAT_ARITH_EN
    logic [REG_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[REG_W] ? '1 : sum[REG_W-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic [REG_W-1:0] sub_op(input logic [REG_W-1:0] a,
                                              input logic [REG_W-1:0] b);
`ifdef GPU_CORE_SAT_ARITH_EN
    return (a < b) ? '0 : a - b;
`else
    return a - b;
`endif
  endfunction

  // Decode of the instruction at PC
  logic [INSN_W-1:0] cur;
  logic [OPC_W-1:0]  opc;
  logic [3:0]        rd, rs0, rs1;
  logic [REG_W-1:0]  op_a, op_b, alu_res;
  logic              alu_wr;
  logic              last;
  logic [PC_W-1:0]   pc_next;

  always_comb begin
    cur     = insn_q[pc_q];
    opc     = cur[INSN_W-1 -: OPC_W];
    rd      = cur[11:8];
    rs0     = cur[7:4];
    rs1     = cur[3:0];
    op_a    = regs_q[rs0];
    op_b    = regs_q[rs1];
    last    = (pc_q == PC_W'(NUM_INSN - 1));
    pc_next = last ? '0 : pc_q + 1'b1;
  end

  always_comb begin
    alu_res = '0;
    alu_wr  = 1'b1;
    case (opc)
      OP_ADD:   alu_res = add_op(op_a, op_b);
      OP_SUB:   alu_res = sub_op(op_a, op_b);
      OP_AND:   alu_res = op_a & op_b;
      OP_OR:    alu_res = op_a | op_b;
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_CMPGE: alu_res = (op_a >= op_b) ? REG_W'(1) : '0;
      default:  alu_wr  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ready_d = ready_q;
    en_d    = en_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    first_d = first_q;
    insn_d  = insn_q;
    regs_d  = regs_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          for (int k = 0; k < NUM_INSN; k++) begin
            insn_d[k] = insn_data[k*INSN_W +: INSN_W];
          end
          for (int r = 0; r < NREG; r++) begin
            regs_d[r] = '0;
          end
          regs_d[0] = init_R0_flag ? init_R0_data : '0;
          pc_d      = '0;
          ready_d   = 1'b0;
          state_d   = S_EXEC;
        end
      end

      S_EXEC: begin
        if (opc == OP_LD || opc == OP_ST) begin
          // PC holds on the memory instruction until the access completes
          addr_d  = ADDR_W'(op_a);
          en_d    = (opc == OP_LD) ? EN_RD : EN_WR;
          if (opc == OP_ST) wdata_d = op_b;
          first_d = 1'b1;
          state_d = S_MEM;
        end else begin
          if (alu_wr) regs_d[rd] = alu_res;
          pc_d = pc_next;
          if (opc == OP_READY || last) state_d = S_DONE;
        end
      end

      S_MEM: begin
        // ready_M in the first MEM cycle may be stale from the memory's view
        // of the previous access, so it is not trusted.
        if (first_q) begin
          first_d = 1'b0;
        end else if (mem.ready_M) begin
          if (en_q == EN_RD) regs_d[rd] = mem.rd_data_M;
          en_d    = EN_IDLE;
          pc_d    = pc_next;
          state_d = last ? S_DONE : S_EXEC;
        end
      end

      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ready_q <= 1'b1;
      en_q    <= EN_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      first_q <= 1'b0;
      for (int k = 0; k < NUM_INSN; k++) insn_q[k] <= '0;
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      first_q <= first_d;
      insn_q  <= insn_d;
      regs_q  <= regs_d;
    end
  end

  assign Ready         = ready_q;
  assign mem.enable_M  = en_q;
  assign mem.addr_M    = addr_q;
  assign mem.wr_data_M = wdata_q;

endmodule

// File: tb/tb_gpu_core.sv
`timescale 1ns/1ps
module tb_gpu_core;
  localparam int REG_W    = 8;
  localparam int ADDR_W   = 8;
  localparam int INSN_W   = 16;
  localparam int OPC_W    = 4;
  localparam int NUM_INSN = 16;

  localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, AND_ = 4'd3, OR_ = 4'd4,
                         XOR_ = 4'd5, CMPGE = 4'd6, LD = 4'd7, ST = 4'd8, RDY = 4'd9;

  logic                       clk;
  logic                       reset;
  logic                       init_R0_flag;
  logic [REG_W-1:0]           init_R0_data;
  logic [NUM_INSN*INSN_W-1:0] insn_data;
  logic                       Start;
  logic                       Ready;

  gpu_core_if #(.REG_W(REG_W), .ADDR_W(ADDR_W)) mif ();

  gpu_core #(
    .REG_W(REG_W), .ADDR_W(ADDR_W), .INSN_W(INSN_W), .OPC_W(OPC_W), .NUM_INSN(NUM_INSN)
  ) dut (
    .clk(clk), .reset(reset), .init_R0_flag(init_R0_flag), .init_R0_data(init_R0_data),
    .insn_data(insn_data), .Start(Start), .Ready(Ready), .mem(mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  acc_t        exp_q[$];
  logic [15:0] prog [NUM_INSN];
  int          resp_lat;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] o, input logic [3:0] d,
                                     input logic [3:0] s0, input logic [3:0] s1);
    return {o, d, s0, s1};
  endfunction

  function automatic logic [7:0] m_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef GPU_CORE_SAT_ARITH_EN
    if (s[8]) return 8'hFF;
`endif
    return s[7:0];
  endfunction

  function automatic logic [7:0] m_sub(input logic [7:0] a, input logic [7:0] b);
`ifdef GPU_CORE_SAT_ARITH_EN
    if (a < b) return 8'h00;
`endif
    return a - b;
  endfunction

  task automatic clear_prog();
    for (int k = 0; k < NUM_INSN; k++) prog[k] = 16'h0000;
  endtask

  // Instruction-level reference: queues the expected memory accesses and
  // returns the final R0.
  task automatic model(input logic flag, input logic [7:0] r0, input logic [7:0] rdv,
                       output logic [7:0] fr0);
    logic [7:0] r [16];
    logic [3:0] o, d, s0, s1;
    acc_t       e;
    bit         stop;
    stop = 0;
    for (int i = 0; i < 16; i++) r[i] = 8'h00;
    if (flag) r[0] = r0;
    for (int k = 0; k < NUM_INSN && !stop; k++) begin
      {o, d, s0, s1} = prog[k];
      case (o)
        ADD:   r[d] = m_add(r[s0], r[s1]);
        SUB:   r[d] = m_sub(r[s0], r[s1]);
        AND_:  r[d] = r[s0] & r[s1];
        OR_:   r[d] = r[s0] | r[s1];
        XOR_:  r[d] = r[s0] ^ r[s1];
        CMPGE: r[d] = (r[s0] >= r[s1]) ? 8'd1 : 8'd0;
        LD: begin
          e.wr = 1'b0; e.addr = r[s0]; e.data = rdv;
          exp_q.push_back(e);
          r[d] = rdv;
        end
        ST: begin
          e.wr = 1'b1; e.addr = r[s0]; e.data = r[s1];
          exp_q.push_back(e);
        end
        RDY:     stop = 1;
        default: ;
      endcase
    end
    fr0 = r[0];
  endtask

  // Memory responder: compares each access against the scoreboard, then
  // answers after resp_lat cycles and waits for enable_M to drop.
  initial begin
    acc_t       e;
    logic [1:0] en0;
    logic [7:0] a0;
    bit         aborted;
    bit         dropped;
    int         held;
    mif.ready_M = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && mif.enable_M != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_access", {30'd0, mif.enable_M}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("acc_kind", {30'd0, mif.enable_M}, e.wr ? 32'd2 : 32'd1);
          check("acc_addr", {24'd0, mif.addr_M}, {24'd0, e.addr});
          if (e.wr) check("acc_data", {24'd0, mif.wr_data_M}, {24'd0, e.data});
        end
        en0 = mif.enable_M;
        a0  = mif.addr_M;
        aborted = 0;
        for (int i = 0; i < resp_lat; i++) begin
          @(negedge clk);
          if (!reset) begin
            aborted = 1;
            break;
          end
        end
        if (!aborted) begin
          check("acc_held", {22'd0, mif.enable_M, mif.addr_M}, {22'd0, en0, a0});
          mif.ready_M = 1'b1;
          held = 0;
          dropped = 0;
          for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mif.enable_M == 2'b00) begin
              dropped = 1;
              break;
            end
            held++;
          end
          mif.ready_M = 1'b0;
          check("acc_done", {31'd0, dropped}, 32'd1);
          check("first_cycle_ignored", held, (resp_lat == 0) ? 32'd1 : 32'd0);
        end
      end
    end
  end

  task automatic run_block(input string name, input logic flag, input logic [7:0] r0,
                           input logic [7:0] rdv, input int lat, input int exp_lat,
                           input bit poke_start);
    logic [7:0] fr0;
    int         n;
    bit         done;
    model(flag, r0, rdv, fr0);
    @(negedge clk);
    for (int k = 0; k < NUM_INSN; k++) insn_data[k*INSN_W +: INSN_W] = prog[k];
    init_R0_flag  = flag;
    init_R0_data  = r0;
    mif.rd_data_M = rdv;
    resp_lat      = lat;
    Start         = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check({name, "_busy"}, {31'd0, Ready}, 32'd0);
    n = 0;
    done = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (poke_start && n == 3) begin
        insn_data    = '0;
        init_R0_flag = 1'b1;
        init_R0_data = 8'hAA;
        Start        = 1'b1;
      end else begin
        Start = 1'b0;
      end
      if (Ready) done = 1;
    end
    Start = 1'b0;
    check({name, "_ready"}, {31'd0, done}, 32'd1);
    if (exp_lat >= 0) check({name, "_latency"}, n, exp_lat);
    check({name, "_all_accesses"}, exp_q.size(), 32'd0);
    exp_q.delete();
    check({name, "_en_idle"}, {30'd0, mif.enable_M}, 32'd0);
    check({name, "_r0"}, {24'd0, dut.regs_q[0]}, {24'd0, fr0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;
    resp_lat = 1;
    reset = 1'b1;
    Start = 1'b0;
    init_R0_flag = 1'b0;
    init_R0_data = '0;
    insn_data = '0;
    mif.rd_data_M = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_ready", {31'd0, Ready}, 32'd1);
    check("rst_enable", {30'd0, mif.enable_M}, 32'd0);
    check("rst_addr", {24'd0, mif.addr_M}, 32'd0);
    check("rst_wdata", {24'd0, mif.wr_data_M}, 32'd0);
    check("rst_r0", {24'd0, dut.regs_q[0]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    clear_prog();
    prog[0] = mk(ST, 0, 0, 0); prog[1] = mk(RDY, 0, 0, 0);
    run_block("st_ready", 1'b0, 8'd0, 8'd0, 2, -1, 0);

    clear_prog();
    prog[0] = mk(CMPGE, 0, 0, 0); prog[1] = mk(ADD, 0, 0, 0);
    prog[2] = mk(ADD, 0, 0, 0);   prog[3] = mk(RDY, 0, 0, 0);
    run_block("cmpge_add", 1'b0, 8'd0, 8'd0, 1, 5, 0);

    clear_prog();
    prog[0] = mk(ADD, 0, 0, 0); prog[1] = mk(ADD, 0, 0, 0);
    prog[2] = mk(ADD, 0, 0, 0); prog[3] = mk(RDY, 0, 0, 0);
    run_block("seed_add3", 1'b1, 8'd3, 8'd0, 1, 5, 0);

    clear_prog();
    prog[0] = mk(LD, 0, 0, 0); prog[1] = mk(ST, 0, 0, 0); prog[2] = mk(RDY, 0, 0, 0);
    run_block("ld_st", 1'b1, 8'd3, 8'd8, 0, -1, 0);

    clear_prog();
    prog[0] = mk(LD, 0, 0, 0);  prog[1] = mk(ADD, 0, 0, 0);
    prog[2] = mk(ADD, 0, 0, 0); prog[3] = mk(RDY, 0, 0, 0);
    run_block("ld_add", 1'b1, 8'd0, 8'd2, 1, -1, 0);

    clear_prog();
    prog[0] = mk(ADD, 0, 0, 0); prog[1] = mk(ST, 0, 0, 0); prog[2] = mk(RDY, 0, 0, 0);
    run_block("add_hi", 1'b1, 8'd200, 8'd0, 3, -1, 0);

    clear_prog();
    prog[0] = mk(SUB, 0, 1, 0); prog[1] = mk(ST, 0, 0, 0); prog[2] = mk(RDY, 0, 0, 0);
    run_block("sub_lo", 1'b1, 8'd5, 8'd0, 1, -1, 0);

    // Full block with no READY: must finish after the last slot
    clear_prog();
    prog[0] = mk(ADD, 1, 0, 0);   prog[1] = mk(AND_, 2, 1, 0);
    prog[2] = mk(OR_, 3, 1, 0);   prog[3] = mk(XOR_, 4, 3, 2);
    prog[4] = mk(CMPGE, 5, 2, 1); prog[5] = mk(CMPGE, 6, 1, 2);
    prog[6] = mk(ST, 0, 4, 3);    prog[7] = mk(ST, 0, 6, 5);
    prog[8] = 16'hF123;           prog[9] = mk(SUB, 0, 3, 6);
    prog[10] = mk(ST, 0, 0, 0);
    run_block("full_block", 1'b1, 8'h5A, 8'd0, 1, -1, 0);

    clear_prog();
    prog[0] = mk(LD, 0, 0, 0);  prog[1] = mk(ADD, 0, 0, 0);
    prog[2] = mk(ADD, 0, 0, 0); prog[3] = mk(RDY, 0, 0, 0);
    run_block("busy_start", 1'b1, 8'd0, 8'd2, 4, -1, 1);

    // Reset in the middle of a memory access
    clear_prog();
    prog[0] = mk(ST, 0, 0, 0); prog[1] = mk(RDY, 0, 0, 0);
    @(negedge clk);
    for (int k = 0; k < NUM_INSN; k++) insn_data[k*INSN_W +: INSN_W] = prog[k];
    init_R0_flag = 1'b1;
    init_R0_data = 8'h77;
    resp_lat = 50;
    begin
      acc_t e;
      e.wr = 1'b1; e.addr = 8'h77; e.data = 8'h77;
      exp_q.push_back(e);
    end
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    n = 0;
    while (mif.enable_M == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mem_entered", {31'd0, (mif.enable_M != 2'b00)}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_enable", {30'd0, mif.enable_M}, 32'd0);
    check("midrst_ready", {31'd0, Ready}, 32'd1);
    check("midrst_addr", {24'd0, mif.addr_M}, 32'd0);
    check("midrst_r0", {24'd0, dut.regs_q[0]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);

    clear_prog();
    prog[0] = mk(CMPGE, 0, 0, 0); prog[1] = mk(ADD, 0, 0, 0);
    prog[2] = mk(ADD, 0, 0, 0);   prog[3] = mk(RDY, 0, 0, 0);
    run_block("after_reset", 1'b0, 8'd0, 8'd0, 1, 5, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
